// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Shares the single DDR2 controller user port (app_*) between N_REQ requesters.
// One command is in flight at a time; outstanding read issuers are queued in a
// tag FIFO so returning read data is steered back to the right requester.
//
// Ports:
//   clk, rst (async, active-low)
//   init_calib_complete        : controller ready, gates all grants
//   req_valid/req_we/req_addr/req_wdata : packed per-requester request
//   req_ready                  : combinational one-cycle acceptance pulse
//   rd_valid/rd_data           : registered one-hot read-return strobe + data
//   app_en/app_cmd/app_addr/app_rdy          : controller command channel
//   app_wdf_wren/app_wdf_end/app_wdf_data/app_wdf_rdy : controller write data
//   app_rd_data/app_rd_data_valid            : controller read return
//   tag_err                    : sticky, read data arrived with no tag pending
//
// Build option: define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration;
// default is round-robin starting after the last granted requester.
module ddr_port_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_calib_complete,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [ADDR_W-1:0]       app_addr,
    input  logic                    app_rdy,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [DATA_W-1:0]       app_wdf_data,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_W-1:0]       app_rd_data,
    input  logic                    app_rd_data_valid,
    output logic                    tag_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  CMD_WR = 3'b000;
    localparam logic [2:0]  CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, WDATA, CMD} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic              app_en_d, wren_d;
    logic [2:0]        app_cmd_d;
    logic [ADDR_W-1:0] app_addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [N_REQ-1:0]  rd_valid_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              tag_err_d;

    logic [IDX_W-1:0]  tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop, fifo_full;

    logic [N_REQ-1:0]  elig;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx, cand;
    int unsigned       start_idx;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
`endif

    // Full check uses occupancy as registered, so a same-cycle pop never frees a slot early.
    assign fifo_full = (count_q == CNT_W'(MAX_OUT));
    assign elig      = req_valid & (req_we | {N_REQ{~fifo_full}}) & {N_REQ{init_calib_complete}};

    // Arbitration, command sequencing and registered-output next values.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        app_cmd_d  = app_cmd;
        app_addr_d = app_addr;
        wdata_d    = app_wdf_data;
        req_ready  = '0;
        push       = 1'b0;
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        start_idx  = 0;
`else
        last_grant_d = last_grant_q;
        start_idx    = (32'(last_grant_q) + 32'd1) % N_REQ;
`endif

        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((start_idx + k) % N_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready  = N_REQ'(1) << win_idx;
                    grant_d    = win_idx;
                    app_addr_d = req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d    = req_wdata[win_idx*DATA_W +: DATA_W];
                    app_cmd_d  = req_we[win_idx] ? CMD_WR : CMD_RD;
                    state_d    = req_we[win_idx] ? WDATA : CMD;
                end
            end
            WDATA: begin
                if (app_wdf_rdy) state_d = CMD;
            end
            CMD: begin
                if (app_rdy) begin
                    state_d = IDLE;
                    push    = (app_cmd == CMD_RD);
`ifndef ARB_FIXED_PRIORITY_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are a pure function of the state being entered.
        app_en_d = (state_d == CMD);
        wren_d   = (state_d == WDATA);
    end

    // Read-return steering from the head of the tag FIFO.
    always_comb begin
        pop        = 1'b0;
        rd_valid_d = '0;
        rd_data_d  = rd_data;
        tag_err_d  = tag_err;
        if (app_rd_data_valid) begin
            if (count_q == '0) begin
                tag_err_d = 1'b1;
            end else begin
                pop        = 1'b1;
                rd_valid_d = N_REQ'(1) << tag_mem[rd_ptr_q];
                rd_data_d  = app_rd_data;
            end
        end
    end

    // State, output and FIFO pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant_q <= IDX_W'(N_REQ - 1);
`endif
            app_en       <= 1'b0;
            app_cmd      <= '0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            rd_valid     <= '0;
            rd_data      <= '0;
            tag_err      <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
            app_en       <= app_en_d;
            app_cmd      <= app_cmd_d;
            app_addr     <= app_addr_d;
            app_wdf_wren <= wren_d;
            app_wdf_end  <= wren_d;
            app_wdf_data <= wdata_d;
            rd_valid     <= rd_valid_d;
            rd_data      <= rd_data_d;
            tag_err      <= tag_err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage; entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= grant_q;
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ddr_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_calib_complete;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rd_valid;
    logic [DW-1:0]   rd_data;
    logic            app_en;
    logic [2:0]      app_cmd;
    logic [AW-1:0]   app_addr;
    logic            app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW-1:0]   app_wdf_data, app_rd_data;
    logic            app_rd_data_valid, tag_err;

    ddr_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one in-flight transaction plus a queue of read issuers.
    bit            m_busy, m_wr, m_wdone, m_err;
    int            m_idx, m_last;
    int            m_tags[$];
    logic [2:0]    m_cmd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdd;
    logic [N-1:0]  m_rdv;

    logic [N-1:0]  obs_ready, obs_rdv;
    logic          obs_en, obs_wren, obs_err;
    logic [DW-1:0] obs_rdd;
    int            c_ready, c_wren, c_en;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_timeout(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_wr = 0; m_wdone = 0; m_err = 0;
        m_idx = 0; m_last = N - 1;
        m_tags.delete();
        m_cmd = '0; m_addr = '0; m_wdata = '0; m_rdd = '0; m_rdv = '0;
    endfunction

    // Requester that must be accepted this cycle, or -1.
    function automatic int pick();
        int c;
        if (m_busy || !init_calib_complete) return -1;
        for (int k = 1; k <= N; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            c = k - 1;
`else
            c = (m_last + k) % N;
`endif
            if (req_valid[c] && (req_we[c] || m_tags.size() < MO)) return c;
        end
        return -1;
    endfunction

    function automatic void model_step(int w);
        if (app_rd_data_valid) begin
            if (m_tags.size() == 0) begin
                m_err = 1;
                m_rdv = '0;
            end else begin
                m_rdv = N'(1 << m_tags.pop_front());
                m_rdd = app_rd_data;
            end
        end else begin
            m_rdv = '0;
        end
        if (m_busy) begin
            if (m_wr && !m_wdone) begin
                if (app_wdf_rdy) m_wdone = 1;
            end else if (app_rdy) begin
                if (!m_wr) m_tags.push_back(m_idx);
                m_last = m_idx;
                m_busy = 0;
            end
        end else if (w >= 0) begin
            m_busy  = 1;
            m_wr    = req_we[w];
            m_wdone = 0;
            m_idx   = w;
            m_cmd   = req_we[w] ? 3'b000 : 3'b001;
            m_addr  = req_addr[w*AW +: AW];
            m_wdata = req_wdata[w*DW +: DW];
        end
    endfunction

    // One clock: compare DUT against model, advance model, move to next negedge.
    task automatic tick();
        int  w;
        bit  e_en, e_wren;
        #1;
        w      = pick();
        e_en   = m_busy && (!m_wr || m_wdone);
        e_wren = m_busy && m_wr && !m_wdone;
        chk("req_ready", DW'(req_ready), (w < 0) ? DW'(0) : DW'(1 << w));
        chk("app_en", DW'(app_en), DW'(e_en));
        chk("app_wdf_wren", DW'(app_wdf_wren), DW'(e_wren));
        chk("app_wdf_end", DW'(app_wdf_end), DW'(e_wren));
        chk("app_cmd", DW'(app_cmd), DW'(m_cmd));
        chk("app_addr", DW'(app_addr), DW'(m_addr));
        chk("app_wdf_data", app_wdf_data, m_wdata);
        chk("rd_valid", DW'(rd_valid), DW'(m_rdv));
        chk("rd_data", rd_data, m_rdd);
        chk("tag_err", DW'(tag_err), DW'(m_err));
        obs_ready = req_ready; obs_rdv = rd_valid; obs_rdd = rd_data;
        obs_en = app_en; obs_wren = app_wdf_wren; obs_err = tag_err;
        if (!rst) model_reset();
        else model_step(w);
        @(negedge clk);
    endtask

    task automatic wtick();
        tick();
        c_ready += int'(obs_ready[2]);
        c_wren  += int'(obs_wren);
        c_en    += int'(obs_en);
    endtask

    // Present one request, wait for acceptance, then let it complete.
    task automatic issue(int idx, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        bit got = 0;
        req_valid = N'(1 << idx);
        req_we    = N'(we) << idx;
        req_addr[idx*AW +: AW] = a;
        req_wdata[idx*DW +: DW] = d;
        for (int t = 0; t < 30 && !got; t++) begin
            tick();
            if (obs_ready[idx]) got = 1;
        end
        req_valid = '0;
        if (!got) fail_timeout("issue");
        repeat (3) tick();
    endtask

    task automatic drain();
        req_valid = '0; app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0;
        repeat (4) tick();
        for (int t = 0; t < 16 && m_tags.size() > 0; t++) begin
            app_rd_data_valid = 1;
            app_rd_data = rnd128();
            tick();
        end
        app_rd_data_valid = 0;
        tick();
    endtask

    task automatic do_reset();
        rst = 0; init_calib_complete = 0; req_valid = '0; app_rd_data_valid = 0;
        model_reset();
        tick();
        rst = 1; init_calib_complete = 1; app_rdy = 1; app_wdf_rdy = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            order[$];
        int            exp_rr[6];
        logic [N-1:0]  seen;
        bit            seen_en;
        logic [DW-1:0] d0, d1, d2;

`ifdef ARB_FIXED_PRIORITY_EN
        exp_rr = '{0, 0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 0, 1, 2};
`endif
        rst = 0; init_calib_complete = 0; req_valid = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; app_rdy = 1; app_wdf_rdy = 1;
        app_rd_data = '0; app_rd_data_valid = 0;
        c_ready = 0; c_wren = 0; c_en = 0;
        model_reset();
        @(negedge clk);
        tick();
        chk("reset_app_en", DW'(app_en), DW'(0));
        chk("reset_tag_err", DW'(tag_err), DW'(0));
        rst = 1;

        // Calibration gate, then round-robin among three continuous readers.
        req_valid = 3'b111; req_we = 3'b000;
        seen = '0; seen_en = 0;
        repeat (20) begin
            tick();
            seen |= obs_ready;
            seen_en |= obs_en;
        end
        chk("calib_gate_ready", DW'(seen), DW'(0));
        chk("calib_gate_app_en", DW'(seen_en), DW'(0));
        init_calib_complete = 1;
        tick();
        chk("calib_first_grant", DW'(obs_ready), DW'(3'b001));
        if (obs_ready[0]) order.push_back(0);
        for (int t = 0; t < 60 && order.size() < 6; t++) begin
            tick();
            for (int i = 0; i < N; i++) if (obs_ready[i]) order.push_back(i);
        end
        if (order.size() < 6) fail_timeout("rr_order");
        for (int k = 0; k < 6 && k < order.size(); k++)
            chk($sformatf("rr_grant_%0d", k), DW'(order[k]), DW'(exp_rr[k]));
        drain();

        // Write with data-channel then command-channel backpressure.
        req_valid = 3'b100; req_we = 3'b100;
        req_addr[2*AW +: AW] = 27'h0000100;
        req_wdata[2*DW +: DW] = {16{8'hA5}};
        app_wdf_rdy = 0; app_rdy = 0;
        c_ready = 0; c_wren = 0; c_en = 0;
        wtick();
        req_valid = '0;
        repeat (5) wtick();
        app_wdf_rdy = 1;
        wtick();
        app_wdf_rdy = 0;
        chk("wr_app_addr", DW'(app_addr), DW'(27'h0000100));
        chk("wr_app_cmd", DW'(app_cmd), DW'(3'b000));
        chk("wr_wdf_data", app_wdf_data, {16{8'hA5}});
        repeat (3) wtick();
        app_rdy = 1;
        wtick();
        wtick();
        chk("wr_ready_pulses", DW'(c_ready), DW'(1));
        chk("wr_wren_cycles", DW'(c_wren), DW'(6));
        chk("wr_en_cycles", DW'(c_en), DW'(4));
        app_wdf_rdy = 1;

        // Tag routing: issue reads 1, 0, 2 and return data in that order.
        issue(1, 0, 27'h10, '0);
        issue(0, 0, 27'h20, '0);
        issue(2, 0, 27'h30, '0);
        d1 = {4{32'h1111_1111}}; d0 = {4{32'h0000_D0D0}}; d2 = {4{32'h2222_2222}};
        app_rd_data_valid = 1; app_rd_data = d1; tick();
        app_rd_data = d0; tick();
        chk("route_valid_1", DW'(obs_rdv), DW'(3'b010));
        chk("route_data_1", obs_rdd, d1);
        app_rd_data = d2; tick();
        chk("route_valid_0", DW'(obs_rdv), DW'(3'b001));
        chk("route_data_0", obs_rdd, d0);
        app_rd_data_valid = 0; tick();
        chk("route_valid_2", DW'(obs_rdv), DW'(3'b100));
        chk("route_data_2", obs_rdd, d2);

        // Tag FIFO full: reads stall while a write from another requester still goes.
        for (int i = 0; i < MO; i++) issue(0, 0, AW'(i), '0);
        req_valid = 3'b011; req_we = 3'b010;
        tick();
        chk("full_write_granted", DW'(obs_ready), DW'(3'b010));
        req_valid = 3'b001;
        seen = '0;
        repeat (3) begin
            tick();
            seen |= obs_ready;
        end
        chk("full_read_stalled", DW'(seen), DW'(0));
        app_rd_data_valid = 1; app_rd_data = rnd128();
        tick();
        chk("full_pop_same_cycle", DW'(obs_ready), DW'(0));
        app_rd_data_valid = 0;
        tick();
        chk("full_read_after_pop", DW'(obs_ready), DW'(3'b001));
        drain();

        // Sticky tag error, then reset during a write-data phase.
        app_rd_data_valid = 1; app_rd_data = rnd128(); tick();
        app_rd_data_valid = 0; tick();
        chk("tag_err_set", DW'(obs_err), DW'(1));
        chk("tag_err_no_rd_valid", DW'(obs_rdv), DW'(0));
        repeat (3) tick();
        chk("tag_err_sticky", DW'(obs_err), DW'(1));
        issue(1, 0, 27'h44, '0);
        issue(2, 0, 27'h48, '0);
        app_wdf_rdy = 0;
        req_valid = 3'b001; req_we = 3'b001;
        tick();
        req_valid = '0;
        tick();
        chk("pre_reset_wren", DW'(obs_wren), DW'(1));
        rst = 0; init_calib_complete = 0; model_reset();
        tick();
        chk("rst_wren", DW'(obs_wren), DW'(0));
        chk("rst_app_en", DW'(obs_en), DW'(0));
        chk("rst_tag_err", DW'(obs_err), DW'(0));
        chk("rst_app_addr", DW'(app_addr), DW'(0));
        rst = 1; init_calib_complete = 1; app_wdf_rdy = 1; app_rdy = 1;
        app_rd_data_valid = 1; app_rd_data = rnd128(); tick();
        app_rd_data_valid = 0; tick();
        chk("rst_fifo_empty_err", DW'(obs_err), DW'(1));
        chk("rst_fifo_empty_rdv", DW'(obs_rdv), DW'(0));
        do_reset();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid = N'($urandom);
            req_we    = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_wdata[i*DW +: DW] = rnd128();
            end
            init_calib_complete = ($urandom_range(15) != 0);
            app_rdy     = ($urandom_range(3) != 0);
            app_wdf_rdy = ($urandom_range(3) != 0);
            app_rd_data_valid = (m_tags.size() > 0) && ($urandom_range(9) < 4);
            app_rd_data = rnd128();
            tick();
        end
        init_calib_complete = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

- Shares the single DDR2 memory-controller user port (app_* interface) between N accelerator requesters: weight loader, feature-map reader, result writer.
- Arbitrates one command at a time, sequences the write-data/command handshakes, and tags outstanding reads so returning read data is steered back to its issuer.
- Sits in FPGA_top between the accelerator datapath and the DDR2 memory controller.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 27, DDR byte address width
- DATA_W, 128, user-port data width
- MAX_OUT, 8, read-tag FIFO depth (power of two)

Ports:
- clk  in  1  system clock (memory-controller ui_clk domain)
- rst  in  1  asynchronous, active-low reset
- init_calib_complete  in  1  controller ready; no grants while 0
- req_valid  in  N_REQ  request pending per requester
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data
- req_ready  out  N_REQ  one-cycle acceptance pulse
- rd_valid  out  N_REQ  one-cycle read-return strobe, one-hot
- rd_data  out  DATA_W  read data, valid with rd_valid
- app_en, app_cmd[2:0], app_addr[ADDR_W]  out  controller command (cmd 000 = write, 001 = read)
- app_rdy  in  1  command accepted
- app_wdf_wren, app_wdf_end  out  1  write-data strobe; end tied equal to wren
- app_wdf_data  out  DATA_W  write data
- app_wdf_rdy  in  1  write data accepted
- app_rd_data  in  DATA_W
- app_rd_data_valid  in  1
- tag_err  out  1  sticky: read data arrived with tag FIFO empty

## Operation
FSM states: IDLE, WDATA, CMD.

IDLE:
- Eligible requester: req_valid=1, init_calib_complete=1, and, for reads, tag FIFO not full.
- Winner chosen round-robin; search starts at last_grant+1 mod N_REQ.
- Winner's req_ready pulses this cycle.
- Winner's addr/we/wdata and the grant index are registered.
- Next state: WDATA for a write, CMD for a read. With no eligible requester, stay in IDLE.

WDATA:
- app_wdf_wren=app_wdf_end=1 with registered data, held until app_wdf_rdy=1, then CMD.

CMD:
- app_en=1 with registered cmd/addr, held until app_rdy=1.
- On a read handshake, push the grant index into the tag FIFO.
- Then IDLE; last_grant updates to the granted index.

Read return:
- On app_rd_data_valid, pop the tag FIFO; rd_valid[tag]=1 and rd_data=app_rd_data, registered one cycle later.
- Valid with FIFO empty: set tag_err, no rd_valid, no pop.

Simultaneous events:
- Push (CMD read handshake) and pop in the same cycle: occupancy unchanged.
- The full check uses occupancy as it stands in the IDLE cycle. A read is never granted at occupancy == MAX_OUT, even if a pop occurs that same cycle.

Reset:
- Reset asserted mid-operation aborts the transaction with no handshake completion.
- FIFO emptied, last_grant = N_REQ-1 (so index 0 is searched first), state IDLE.

## Timing
- Reset values: all outputs 0 (req_ready, rd_valid, rd_data, app_en, app_cmd, app_addr, app_wdf_*, tag_err).
- req_ready is combinational from req_valid/state/FIFO count; all other outputs are registered.
- Minimum command spacing: read = 2 cycles (IDLE, CMD); write = 3 cycles (IDLE, WDATA, CMD), with app_rdy/app_wdf_rdy tied 1.
- Read return latency: rd_valid one cycle after app_rd_data_valid.
- Returns are in order, matching controller ordering.
- app_en/app_wdf_wren never drop before their handshake completes.
- app_addr/app_cmd/app_wdf_data stay stable while held.

## Configuration
- ARB_FIXED_PRIORITY_EN defined: grant goes to the lowest-indexed eligible requester; last_grant unused.
- ARB_FIXED_PRIORITY_EN undefined (default): round-robin as described above.

## Test plan
- Calibration gate: init_calib_complete=0, req_valid=3'b111 for 20 cycles -> no req_ready, app_en stays 0. Raise calib -> requester 0 granted first.
- Round-robin: all three issue continuous reads, app_rdy=1 -> grant order 0,1,2,0,1,2. With ARB_FIXED_PRIORITY_EN -> 0,0,0…
- Write backpressure: req 2 writes addr 0x0000100, data 0xA5…A5; app_wdf_rdy low 5 cycles, then app_rdy low 3 cycles -> wren held 6 cycles, then app_en held 4 cycles; one req_ready pulse total.
- Tag routing: reads from req 1, 0, 2 in order; controller returns D1, D0, D2 -> rd_valid pulses 3'b010, 3'b001, 3'b100 with matching rd_data.
- FIFO full: 8 reads issued with no returns -> 9th read stalls in IDLE while a pending write from another requester is still granted. One return -> read granted.
- Error/reset: app_rd_data_valid with FIFO empty -> tag_err=1 and stays 1. Assert rst in WDATA -> all outputs 0 next edge, FIFO empty, tag_err cleared.
